// File: rtl/ripple_pkg.sv
// ripple_pkg
// Shared definitions for the ripple counter capture path.
//   RIPPLE_WIDTH      : default count width (matches the ripple counter)
//   STABLE_CYCLES_MAX : largest legal STABLE_CYCLES (the stab counter is 4 bits)
//   state_t           : capture FSM states
package ripple_pkg;

    localparam int RIPPLE_WIDTH      = 8;
    localparam int STABLE_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,  // nothing published since reset
        SETTLING = 2'd1,  // a candidate differs from count_o
        HOLD     = 2'd2   // synchronised value equals count_o
    } state_t;

endpackage

// File: rtl/ripple_sampler_sync2.sv
// sync2
// WIDTH-wide two-flop synchroniser for ripple outputs entering a clock
// domain. Bits are synchronised individually; the caller is responsible for
// rejecting mixed-generation words (see ripple_sampler's stability filter).
// Ports:
//   clk_i  : destination clock, rising edge
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input word
//   q_o    : synchronised word (second stage)
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ripple_sampler.sv
// ripple_sampler
// Captures the output of an asynchronous ripple counter: two-flop
// synchroniser, stability filter, and a publish FSM that emits each new
// settled value with a single-cycle valid pulse and a threshold-hit flag.
// Optional feature macro: RIPPLE_SAMPLER_DELTA_EN adds delta_o / wrap_o,
// the modulo increment since the previous published value.
// Parameters:
//   WIDTH         : count width
//   STABLE_CYCLES : identical synchronised samples needed to publish (1..15)
// Ports:
//   clock    : sampling clock, rising edge
//   reset    : asynchronous active-low reset
//   count_in : raw ripple count (asynchronous)
//   thresh   : compare value, sampled only on the publish edge
//   count_o  : last published settled count
//   valid_o  : one-cycle pulse when count_o updates
//   hit_o    : one-cycle pulse with valid_o when published value == thresh
//   state_o  : FSM state, debug visibility
//   delta_o  : (new - old) mod 2^WIDTH            [RIPPLE_SAMPLER_DELTA_EN]
//   wrap_o   : pulse with valid_o when new < old  [RIPPLE_SAMPLER_DELTA_EN]
// Handshake: valid_o is a pure strobe with no ready; the consumer must take
// count_o/hit_o (and delta_o/wrap_o) in the cycle valid_o is high.
module ripple_sampler
    import ripple_pkg::*;
#(
    parameter int WIDTH         = RIPPLE_WIDTH,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] count_o,
    output logic             valid_o,
    output logic             hit_o,
    output state_t           state_o
`ifdef RIPPLE_SAMPLER_DELTA_EN
    ,
    output logic [WIDTH-1:0] delta_o,
    output logic             wrap_o
`endif
);

    localparam logic [3:0] STAB_SAT = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3_q;
    logic [2:0]       fill_q;
    logic [3:0]       stab_q;
    logic [3:0]       stab_d;
    logic             same;
    logic             stab_ready;
    logic             publish;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             valid_q;
    logic             hit_q;
`ifdef RIPPLE_SAMPLER_DELTA_EN
    logic [WIDTH-1:0] delta_q;
    logic             wrap_q;
`endif

    sync2 #(
        .WIDTH (WIDTH)
    ) u_sync2 (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (count_in),
        .q_o    (s2)
    );

    // fill_q marks which pipeline stages hold a sample taken after reset
    // released. The reset zeros in s2/s3 are not real samples, so s3 only
    // counts once it carries the first post-reset sample (bit 2). This makes
    // reset release behave like a count change just before the first edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_q <= '0;
            s3_q   <= '0;
            stab_q <= '0;
        end else begin
            fill_q <= {fill_q[1:0], 1'b1};
            s3_q   <= s2;
            stab_q <= stab_d;
        end
    end

    assign same = fill_q[2] && (s2 == s3_q);

    always_comb begin
        stab_d = '0;
        if (same) begin
            stab_d = (stab_q == STAB_SAT) ? stab_q : stab_q + 4'd1;
        end
    end

    // Publish on the edge where stab reaches STABLE_CYCLES-1 with s2==s3;
    // together with the first matching pair this gives STABLE_CYCLES
    // identical synchronised samples.
    assign stab_ready = same && ((int'(stab_q) + 1) >= (STABLE_CYCLES - 1));

    always_comb begin
        publish = 1'b0;
        case (state_q)
            EMPTY:    publish = stab_ready;
            SETTLING: publish = stab_ready && (s2 != count_q);
            default:  publish = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
`ifdef RIPPLE_SAMPLER_DELTA_EN
            delta_q <= '0;
            wrap_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
`ifdef RIPPLE_SAMPLER_DELTA_EN
            wrap_q  <= 1'b0;
`endif
            if (publish) begin
                count_q <= s2;
                valid_q <= 1'b1;
                hit_q   <= (s2 == thresh);
`ifdef RIPPLE_SAMPLER_DELTA_EN
                // First publish measures from zero and never reports a wrap.
                if (state_q == EMPTY) begin
                    delta_q <= s2;
                    wrap_q  <= 1'b0;
                end else begin
                    delta_q <= s2 - count_q;
                    wrap_q  <= (s2 < count_q);
                end
`endif
            end

            case (state_q)
                EMPTY: begin
                    if (publish) state_q <= HOLD;
                end
                HOLD: begin
                    if (s2 != count_q) state_q <= SETTLING;
                end
                SETTLING: begin
                    // Returning to the held value rejects the excursion.
                    if (s2 == count_q) state_q <= HOLD;
                    else if (publish)  state_q <= HOLD;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign hit_o   = hit_q;
    assign state_o = state_q;
`ifdef RIPPLE_SAMPLER_DELTA_EN
    assign delta_o = delta_q;
    assign wrap_o  = wrap_q;
`endif

endmodule
